psum_ofifo: RTL and testbench
=============================

# psum_ofifo

Output FIFO directly downstream of `mac_array`. It captures the per-column partial sums that the array emits on `out` with per-column `fifo_wr` strobes. It realigns the column skew so that one complete row, one psum per column, is presented at a time. The downstream SFU/readout logic pops whole rows with a single read strobe.

## Interface
- `col`, default 8: number of MAC columns, equal to `mac_array` `col`.
- `bw_psum`, default 22: psum width per column.
- `depth`, default 16: entries per column FIFO; must be a power of 2, ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low. Low clears all state immediately, independent of `clk`.
- `in`  in  `col*bw_psum`: psum bus from `mac_array.out`; column c occupies bits `[c*bw_psum +: bw_psum]`.
- `wr`  in  `col`: per-column write strobes from `mac_array.fifo_wr`.
- `rd`  in  1: pop one row from all columns.
- `out`  out  `col*bw_psum`: head row, same column packing as `in`.
- `o_valid`  out  1: every column holds ≥ 1 entry.
- `o_full`  out  1: at least one column holds `depth` entries.
- `o_ready`  out  1: no column is full; equals `~o_full`.
- `o_overflow`  out  1: sticky; a write was dropped.
- `o_underflow`  out  1: sticky; `rd` was asserted while `o_valid` was low.

## Operation
- Each column c has its own circular buffer of `depth` × `bw_psum`.
  - Write pointer `wp[c]` and read pointer `rp[c]`, each `log2(depth)+1` bits. The MSB is the wrap bit.
  - `empty[c]` = pointers equal.
  - `full[c]` = low bits equal and MSBs differ.
- Pop: `pop = rd & o_valid`. When `pop` is 1, every `rp[c]` increments by 1, modulo `2*depth`. Columns never pop individually.
- Write to column c: on `wr[c]`, if `~full[c] | pop`, store `in[c]` at `wp[c]` and increment `wp[c]`.
- Dropped write: if `full[c]` and `~pop`, the data is discarded, `wp[c]` is unchanged, and `o_overflow` is set.
- Columns are independent, so skewed arrival (column c writing k cycles after column 0) is the normal case.
- `rd` with `~o_valid`: no pointer moves and `o_underflow` is set.
- Sticky flags clear only on reset.
- Psum data is stored and returned bit-exact. There is no arithmetic, sign extension or truncation.
- `out` is first-word-fall-through: `out[c]` = `mem[c][rp[c]]`, driven from registered storage and pointers.
- `out` is undefined (don't-care) while `o_valid` is 0. The verifier must check it only when `o_valid` is 1.
- `o_valid` = AND of `~empty[c]`.
- `o_full` = OR of `full[c]`.
- Both flags are derived from registered pointers only, with no combinational path from `wr` or `rd`.
- Reset, including when asserted mid-operation:
  - all pointers go to 0;
  - `o_valid`=0, `o_full`=0, `o_ready`=1, `o_overflow`=0, `o_underflow`=0;
  - memory contents are not cleared;
  - in-flight writes and pops in the same cycle are discarded.

## Timing
- Write-to-visibility latency is 1 cycle. A write at edge N is reflected in `o_valid` and `out` after edge N.
- A row becomes valid the cycle after the edge on which its last-arriving column wrote. With standard `mac_array` skew this is `col-1` cycles after column 0's write.
- A pop at edge N advances `out` to the next row after edge N.
  - If the next row is complete, `o_valid` stays 1 and back-to-back pops at 1 row/cycle are sustained.
  - Otherwise `o_valid` drops after edge N.
- Simultaneous write and pop on a non-full, non-empty column: both occur and the occupancy is unchanged.
- Simultaneous write and pop on a full column: the write is accepted and `full[c]` stays 1.
- Write to an empty column while another column is empty: `o_valid` stays 0, no pop is possible, and the write is accepted.
- Pointer wrap: after `2*depth` operations the pointers return to 0 and behaviour is seamless. No state machine is needed beyond the pointers and flags.
- Reset deassertion is synchronised by the integrating top. The block requires `reset` to be high for ≥ 1 cycle before the first `wr` or `rd`.

## Test plan
- **Reset.** Drive `reset`=0 mid-stream with 5 rows queued. Required:
  - immediately `o_valid`=0, `o_full`=0, `o_ready`=1, both sticky flags 0;
  - after release, a new write is read back correctly.
- **Skewed fill, col=8.**
  - Stimulus: column c writes `100+c` at cycle c (c = 0..7), then `rd` each cycle.
  - Required: `o_valid` rises the cycle after column 7's write; `out[c]` = `100+c`; `o_valid` drops after the pop.
- **Streaming.**
  - Stimulus: 20 rows with values `r*8+c` (r = 0..19, c = 0..7), written with skew while `rd` is held high.
  - Required: rows emerge in order, none lost, pointers wrap past depth 16.
- **Full/overflow.**
  - Stimulus: write 16 entries to column 3 only, then a 17th value `0x3FFFFF` with no pop.
  - Required: `o_full`=1, `o_ready`=0, `o_overflow`=1.
  - After filling the other columns, 16 pops return the first 16 values of column 3.
- **Full + simultaneous pop.**
  - Stimulus: all columns full, then assert `rd` with `wr`=all-ones carrying `0x00ABCD`.
  - Required: write accepted, `o_overflow` stays 0, and the last row read back is `0x00ABCD` in every column.
- **Underflow.** Assert `rd` with one column empty. Required: `o_underflow`=1, no pointer change, other columns' data intact.

Source files
------------

// File: rtl/psum_ofifo_if.sv
// Row-realigning psum FIFO bus: column write side from mac_array, row read side to SFU.
interface psum_ofifo_if #(
  parameter int col     = 8,
  parameter int bw_psum = 22
);
  logic [col*bw_psum-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [col*bw_psum-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   o_overflow;
  logic                   o_underflow;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_full, o_ready, o_overflow, o_underflow
  );
  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_full, o_ready, o_overflow, o_underflow
  );
endinterface

// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column circular buffers that absorb mac_array column skew and
// present one complete row at a time (first-word-fall-through), popped as a unit.

// One column lane: circular buffer with wrap-bit pointers.
module psum_ofifo_col #(
  parameter int bw_psum = 22,
  parameter int depth   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_i,
  input  logic [bw_psum-1:0] din_i,
  input  logic               pop_i,
  output logic [bw_psum-1:0] dout_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               drop_o
);
  localparam int AW = $clog2(depth);

  logic [bw_psum-1:0] mem_q [depth];
  logic [AW:0]        wp_q, wp_d, rp_q, rp_d;
  logic               we;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
  // A pop in the same cycle frees the head slot, so a full column still accepts.
  assign we      = wr_i & (~full_o | pop_i);
  assign drop_o  = wr_i & full_o & ~pop_i;
  assign wp_d    = we    ? wp_q + (AW+1)'(1) : wp_q;
  assign rp_d    = pop_i ? rp_q + (AW+1)'(1) : rp_q;
  assign dout_o  = mem_q[rp_q[AW-1:0]];

  // Pointer state; wraps modulo 2*depth naturally through the extra MSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  // Storage is not cleared by reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (we && reset) mem_q[wp_q[AW-1:0]] <= din_i;
  end
endmodule

module psum_ofifo #(
  parameter int col     = 8,
  parameter int bw_psum = 22,
  parameter int depth   = 16
) (
  input  logic        clk,
  input  logic        reset,
  psum_ofifo_if.slave bus
);
  logic [col-1:0] empty, full, drop;
  logic           valid, pop;
  logic           ovf_q, ovf_d, udf_q, udf_d;

  // Row is only visible once every column holds its entry.
  assign valid = ~|empty;
  assign pop   = bus.rd & valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    psum_ofifo_col #(.bw_psum(bw_psum), .depth(depth)) u_col (
      .clk     (clk),
      .reset   (reset),
      .wr_i    (bus.wr[c]),
      .din_i   (bus.in[c*bw_psum +: bw_psum]),
      .pop_i   (pop),
      .dout_o  (bus.out[c*bw_psum +: bw_psum]),
      .empty_o (empty[c]),
      .full_o  (full[c]),
      .drop_o  (drop[c])
    );
  end

  assign ovf_d = ovf_q | (|drop);
  assign udf_d = udf_q | (bus.rd & ~valid);

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.o_valid     = valid;
  assign bus.o_full      = |full;
  assign bus.o_ready     = ~(|full);
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;
endmodule

// File: tb/tb_psum_ofifo.sv
// Scoreboard bench for psum_ofifo: per-column expected queues filled as writes
// are driven, heads compared against the DUT row whenever a row is valid.
module tb_psum_ofifo;
  localparam int COL = 8;
  localparam int BW  = 22;
  localparam int DEP = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  psum_ofifo_if #(.col(COL), .bw_psum(BW)) bus ();
  psum_ofifo #(.col(COL), .bw_psum(BW), .depth(DEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [BW-1:0] mq [COL][$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COL*BW-1:0] row_all(input logic [BW-1:0] v);
    logic [COL*BW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*BW +: BW] = v;
    return r;
  endfunction

  // One clock: check DUT state against model, drive inputs, advance the model.
  task automatic cyc(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
    logic mv;
    logic [COL-1:0] mf;
    @(negedge clk);
    mv = 1'b1;
    for (int c = 0; c < COL; c++) begin
      if (mq[c].size() == 0) mv = 1'b0;
      mf[c] = (mq[c].size() == DEP);
    end
    chk("valid", bus.o_valid, mv);
    chk("full", bus.o_full, |mf);
    chk("ready", bus.o_ready, ~|mf);
    chk("overflow", bus.o_overflow, m_ovf);
    chk("underflow", bus.o_underflow, m_udf);
    if (mv)
      for (int c = 0; c < COL; c++)
        chk($sformatf("out[%0d]", c), bus.out[c*BW +: BW], mq[c][0]);
    bus.wr = w;
    bus.in = d;
    bus.rd = r;
    if (r && !mv) m_udf = 1'b1;
    for (int c = 0; c < COL; c++) begin
      if (r && mv) void'(mq[c].pop_front());
      if (w[c]) begin
        if (!mf[c] || (r && mv)) mq[c].push_back(d[c*BW +: BW]);
        else m_ovf = 1'b1;
      end
    end
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.wr = '0;
    bus.rd = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk({tag, "_valid"}, bus.o_valid, 1'b0);
    chk({tag, "_full"}, bus.o_full, 1'b0);
    chk({tag, "_ready"}, bus.o_ready, 1'b1);
    chk({tag, "_ovf"}, bus.o_overflow, 1'b0);
    chk({tag, "_udf"}, bus.o_underflow, 1'b0);
    for (int c = 0; c < COL; c++) mq[c].delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [COL*BW-1:0] d;
    logic [COL-1:0] w;
    bus.wr = '0;
    bus.rd = 1'b0;
    bus.in = '0;
    do_reset("rst0");

    // Skewed fill: column c writes 100+c on cycle c, then a single pop.
    for (int c = 0; c < COL; c++) cyc(COL'(1) << c, row_all(BW'(100 + c)), 1'b0);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b0);

    // Streaming: 20 skewed rows with rd held high, pointers wrap past depth.
    for (int t = 0; t < 20 + COL - 1; t++) begin
      w = '0;
      d = '0;
      for (int c = 0; c < COL; c++) begin
        if (t - c >= 0 && t - c < 20) begin
          w[c] = 1'b1;
          d[c*BW +: BW] = BW'((t - c) * 8 + c);
        end
      end
      cyc(w, d, 1'b1);
    end
    for (int i = 0; i < 3; i++) cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);

    // Reset with 5 rows queued, then a fresh row reads back.
    for (int i = 0; i < 5; i++) cyc('1, row_all(BW'(22'h150 + i)), 1'b0);
    cyc('0, '0, 1'b0);
    do_reset("rst_mid");
    for (int c = 0; c < COL; c++) d[c*BW +: BW] = BW'(22'h2A000 + c);
    cyc('1, d, 1'b0);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);

    // Full/overflow on column 3, then fill others and drain.
    for (int i = 0; i < DEP; i++) cyc(8'h08, row_all(BW'(22'h1000 + i)), 1'b0);
    cyc(8'h08, row_all(22'h3FFFFF), 1'b0);
    cyc('0, '0, 1'b0);
    for (int i = 0; i < DEP; i++) cyc(8'hF7, row_all(BW'(22'h2000 + i)), 1'b0);
    for (int i = 0; i < DEP; i++) cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);

    // All columns full with simultaneous pop and write.
    do_reset("rst_fp");
    for (int i = 0; i < DEP; i++) cyc('1, row_all(BW'($urandom_range(0, 22'h3FFFFF))), 1'b0);
    cyc('0, '0, 1'b0);
    cyc('1, row_all(22'h00ABCD), 1'b1);
    for (int i = 0; i < DEP; i++) cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);

    // Underflow: rd while column 7 is empty must not disturb the others.
    do_reset("rst_uf");
    for (int i = 0; i < 2; i++) cyc(8'h7F, row_all(BW'(22'h3300 + i)), 1'b0);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);
    cyc(8'h80, row_all(22'h0777), 1'b0);
    cyc(8'h80, row_all(22'h0778), 1'b0);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
